// File: rtl/aes_sbox_lanes.sv
// aes_sbox_lanes: LANES two-share masked AES S-boxes with valid/ready flow control and a credit-limited output FIFO.
// Define INTERNAL_PRNG_EN to replace the external randomness port with per-lane 16-bit LFSRs.

module aes_sbox_ti_core #(
    parameter int LAT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  s0_i,
    input  logic [7:0]  s1_i,
    input  logic [15:0] rnd_i,
    output logic [7:0]  s0_o,
    output logic [7:0]  s1_o
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Squaring is GF(2)-linear, so it is applied to each share on its own.
    function automatic logic [15:0] sqs(input logic [15:0] a);
        return {gmul(a[15:8], a[15:8]), gmul(a[7:0], a[7:0])};
    endfunction

    // Domain-oriented masked multiply of share pairs {s1,s0}, cross terms refreshed with z.
    function automatic logic [15:0] dom(input logic [15:0] a, input logic [15:0] b, input logic [7:0] z);
        return {gmul(a[15:8], b[15:8]) ^ gmul(a[15:8], b[7:0]) ^ z,
                gmul(a[7:0], b[7:0]) ^ gmul(a[7:0], b[15:8]) ^ z};
    endfunction

    function automatic logic [7:0] lin(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]};
    endfunction

    logic [15:0] x3_q, x2a_q, r1_q, x15_q, x12_q, x2b_q, r2_q, x252_q, x2c_q, r3_q, y_q;
    logic [15:0] x3_d, x2a_d, x15_d, x12_d, x252_d, x254, y_d;
    logic [7:0]  zc, zd;

    // Inversion as x^254 = x^2 * x^252 with x^3, x^15, x^252 built on the way: one masked multiply per stage.
    always_comb begin
        x2a_d  = sqs({s1_i, s0_i});
        x3_d   = dom(x2a_d, {s1_i, s0_i}, rnd_i[7:0]);
        x12_d  = sqs(sqs(x3_q));
        x15_d  = dom(x12_d, x3_q, r1_q[15:8]);
        zc     = r2_q[7:0] ^ {r2_q[11:8], r2_q[15:12]};
        x252_d = dom(sqs(sqs(sqs(sqs(x15_q)))), x12_q, zc);
        zd     = r3_q[15:8] ^ {r3_q[4:0], r3_q[7:5]};
        x254   = dom(x252_q, x2c_q, zd);
        y_d    = {lin(x254[15:8]) ^ 8'h63, lin(x254[7:0])};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            {x3_q, x2a_q, r1_q, x15_q, x12_q, x2b_q, r2_q, x252_q, x2c_q, r3_q, y_q} <= '0;
        end else begin
            x3_q   <= x3_d;
            x2a_q  <= x2a_d;
            r1_q   <= rnd_i;
            x15_q  <= x15_d;
            x12_q  <= x12_d;
            x2b_q  <= x2a_q;
            r2_q   <= r1_q;
            x252_q <= x252_d;
            x2c_q  <= x2b_q;
            r3_q   <= r2_q;
            y_q    <= y_d;
        end
    end

    // Extra output stages when the configured latency exceeds the four arithmetic stages.
    if (LAT > 4) begin : g_pad
        logic [15:0] pad_q [LAT-4];
        always_ff @(posedge clk_i) begin
            pad_q[0] <= rst_ni ? y_q : '0;
            for (int i = 1; i < LAT - 4; i++) pad_q[i] <= rst_ni ? pad_q[i-1] : '0;
        end
        assign {s1_o, s0_o} = pad_q[LAT-5];
    end else begin : g_nopad
        assign {s1_o, s0_o} = y_q;
    end
endmodule

module aes_sbox_lanes #(
    parameter int LANES      = 4,
    parameter int CORE_LAT   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [8*LANES-1:0]                in_share0,
    input  logic [8*LANES-1:0]                in_share1,
    input  logic                              rnd_valid,
    output logic                              rnd_ready,
    input  logic [16*LANES-1:0]               rnd_data,
    input  logic [16*LANES-1:0]               prng_seed,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [8*LANES-1:0]                out_share0,
    output logic [8*LANES-1:0]                out_share1,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   credits_used
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int W  = 16 * LANES;

    logic                 accept, push, pop;
    logic [16*LANES-1:0]  rnd, core_r;
    logic [8*LANES-1:0]   core_s0, core_s1, core_o0, core_o1;
    logic [CORE_LAT-1:0]  vpipe_q, vpipe_d;
    logic [CW-1:0]        cred_q, cred_d, cnt_q, cnt_d;
    logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0]         mem_q [FIFO_DEPTH];

`ifdef INTERNAL_PRNG_EN
    logic [16*LANES-1:0] lfsr_q, lfsr_d;
    logic                unused_rnd;

    function automatic logic [15:0] lfsr16(input logic [15:0] s);
        logic [15:0] v;
        v = s;
        for (int i = 0; i < 16; i++) v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
        return v;
    endfunction

    always_comb begin
        lfsr_d = lfsr_q;
        for (int i = 0; i < LANES; i++)
            lfsr_d[16*i +: 16] = reset ? (prng_seed[16*i +: 16] == 16'h0 ? 16'hACE1 : prng_seed[16*i +: 16])
                               : accept ? lfsr16(lfsr_q[16*i +: 16]) : lfsr_q[16*i +: 16];
    end

    always_ff @(posedge clock) lfsr_q <= lfsr_d;

    assign rnd        = lfsr_q;
    assign accept     = in_valid & in_ready;
    assign rnd_ready  = 1'b0;
    assign unused_rnd = ^{rnd_valid, rnd_data};
`else
    logic unused_seed;
    assign rnd         = rnd_data;
    assign accept      = in_valid & rnd_valid & in_ready;
    assign rnd_ready   = accept;
    assign unused_seed = ^prng_seed;
`endif

    // Credits cover both in-flight and stored entries, so a push always finds room.
    assign in_ready     = (cred_q < CW'(FIFO_DEPTH)) & ~reset;
    assign credits_used = cred_q;

    assign core_s0 = accept ? in_share0 : '0;
    assign core_s1 = accept ? in_share1 : '0;
    assign core_r  = accept ? rnd : '0;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_sbox_ti_core #(.LAT(CORE_LAT)) u_core (
            .clk_i  (clock),
            .rst_ni (~reset),
            .s0_i   (core_s0[8*l +: 8]),
            .s1_i   (core_s1[8*l +: 8]),
            .rnd_i  (core_r[16*l +: 16]),
            .s0_o   (core_o0[8*l +: 8]),
            .s1_o   (core_o1[8*l +: 8])
        );
    end

    assign push       = vpipe_q[CORE_LAT-1];
    assign out_valid  = (cnt_q != '0) & ~reset;
    assign pop        = out_valid & out_ready;
    assign out_share0 = out_valid ? mem_q[rd_q][8*LANES-1:0] : '0;
    assign out_share1 = out_valid ? mem_q[rd_q][W-1:8*LANES] : '0;

    always_comb begin
        vpipe_d = {vpipe_q[CORE_LAT-2:0], accept};
        cred_d  = cred_q + CW'(accept) - CW'(pop);
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        wr_d    = !push ? wr_q : (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
        rd_d    = !pop ? rd_q : (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vpipe_q <= '0;
            cred_q  <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            vpipe_q <= vpipe_d;
            cred_q  <= cred_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset) mem_q[wr_q] <= {core_o1, core_o0};
    end
endmodule

// File: tb/tb_aes_sbox_lanes.sv
// tb_aes_sbox_lanes: vector table, random scoreboard and flow-control sequences for aes_sbox_lanes (LANES=4).
module tb_aes_sbox_lanes;
    logic        clock, reset, in_valid, in_ready, rnd_valid, rnd_ready, out_valid, out_ready;
    logic [31:0] in_share0, in_share1, out_share0, out_share1;
    logic [63:0] rnd_data, prng_seed;
    logic [3:0]  credits_used;

    int nchk = 0, nfail = 0, cyc = 0, cred_m = 0;
    logic [7:0] sb [256];

    typedef struct { logic [31:0] d; int t; } ent_t;
    ent_t q[$];

    typedef struct { logic [31:0] s0, s1, e; } vec_t;
    vec_t vt[4];

    aes_sbox_lanes dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_share0(in_share0), .in_share1(in_share1), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .rnd_data(rnd_data), .prng_seed(prng_seed), .out_valid(out_valid), .out_ready(out_ready),
        .out_share0(out_share0), .out_share1(out_share1), .credits_used(credits_used)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Carry-less product reduced by long division modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h11b << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv, b, c;
        inv = 0;
        c = 8'h63;
        for (int y = 1; y < 256; y++) if (gm(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return b;
    endfunction

    function automatic logic [31:0] sb4(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    function automatic bit will_acc();
`ifdef INTERNAL_PRNG_EN
        return in_valid && in_ready;
`else
        return in_valid && rnd_valid && in_ready;
`endif
    endfunction

    // Scoreboard: every accepted word is expected at the head five cycles later, in order.
    always @(negedge clock) begin
        logic acc_m, ov_m;
        cyc++;
        if (reset) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_rnd_ready", rnd_ready, 0);
            chk("rst_out_shares", {out_share1, out_share0}, 0);
            q.delete();
            cred_m = 0;
        end else begin
            ov_m = q.size() > 0 && q[0].t <= cyc;
            chk("mon_out_valid", out_valid, ov_m);
            if (ov_m) chk("mon_out_data", out_share0 ^ out_share1, q[0].d);
            else chk("mon_idle_shares", {out_share1, out_share0}, 0);
            chk("mon_credits", credits_used, cred_m);
            chk("mon_in_ready", in_ready, cred_m < 8);
`ifdef INTERNAL_PRNG_EN
            acc_m = in_valid && in_ready;
            chk("mon_rnd_ready", rnd_ready, 0);
`else
            acc_m = in_valid && rnd_valid && in_ready;
            chk("mon_rnd_ready", rnd_ready, acc_m);
`endif
            if (ov_m && out_ready) void'(q.pop_front());
            if (acc_m) q.push_back('{sb4(in_share0 ^ in_share1), cyc + 5});
            cred_m = cred_m + int'(acc_m) - int'(ov_m && out_ready);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        in_valid = 0;
        out_ready = 1;
        for (int i = 0; i < 200 && credits_used != 0; i++) step();
        chk("drain", credits_used, 0);
    endtask

    task automatic run_vec(input string nm, input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] e);
        int lat;
        lat = -1;
        in_valid = 1;
        rnd_valid = 1;
        out_ready = 1;
        in_share0 = s0;
        in_share1 = s1;
        rnd_data = {$urandom, $urandom};
        for (int n = 1; n <= 8 && lat < 0; n++) begin
            step();
            in_valid = 0;
            if (out_valid) lat = n;
        end
        chk({nm, "_latency"}, lat, 5);
        chk({nm, "_value"}, out_share0 ^ out_share1, e);
    endtask

    initial begin
        int acc, nout, first, last;
        logic [31:0] sh [3];
        for (int i = 0; i < 256; i++) sb[i] = sbox(8'(i));
        vt[0] = '{32'hFFAA1200, 32'hFFF91300, 32'h63ED7C63};
        vt[1] = '{32'h3CA577E1, 32'hC32567EE, 32'h16CDCA76};
        vt[2] = '{32'h11223344, 32'h4223334B, 32'hED7C6376};
        vt[3] = '{32'h00000000, 32'h00000000, 32'h63636363};
        reset = 1;
        in_valid = 1;
        rnd_valid = 1;
        out_ready = 0;
        in_share0 = 0;
        in_share1 = 0;
        rnd_data = 0;
        prng_seed = 0;
        repeat (3) step();
        chk("reset_credits", credits_used, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        reset = 0;
        in_valid = 0;
        #1;
        chk("post_reset_in_ready", in_ready, 1);

        for (int i = 0; i < 4; i++) run_vec($sformatf("vec%0d", i), vt[i].s0, vt[i].s1, vt[i].e);

        // Random stream with random back-pressure, checked by the scoreboard.
        drain();
        acc = 0;
        for (int i = 0; i < 5000 && acc < 1000; i++) begin
            in_valid = $urandom_range(0, 9) < 8;
            rnd_valid = $urandom_range(0, 9) < 8;
            out_ready = $urandom_range(0, 3) != 0;
            in_share0 = $urandom;
            in_share1 = $urandom;
            rnd_data = {$urandom, $urandom};
            if (will_acc()) acc++;
            step();
        end
        chk("rand_accepts", acc, 1000);

        // Stall: exactly FIFO_DEPTH accepts, then drain in order.
        drain();
        out_ready = 0;
        in_valid = 1;
        rnd_valid = 1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            in_share0 = $urandom;
            in_share1 = $urandom;
            rnd_data = {$urandom, $urandom};
            if (will_acc()) acc++;
            step();
        end
        chk("stall_accepts", acc, 8);
        chk("stall_credits", credits_used, 8);
        chk("stall_in_ready", in_ready, 0);
        in_valid = 0;
        out_ready = 1;
        nout = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) nout++;
            step();
        end
        chk("stall_outputs", nout, 8);
        chk("stall_in_ready_back", in_ready, 1);

        // Throughput: 100 back-to-back accepts, 100 contiguous outputs.
        drain();
        in_valid = 1;
        rnd_valid = 1;
        out_ready = 1;
        acc = 0;
        nout = 0;
        first = -1;
        last = -1;
        for (int t = 1; t <= 110; t++) begin
            in_share0 = $urandom;
            in_share1 = $urandom;
            rnd_data = {$urandom, $urandom};
            if (will_acc()) acc++;
            step();
            if (t == 100) in_valid = 0;
            if (out_valid) begin
                if (first < 0) first = t;
                last = t;
                nout++;
            end
        end
        chk("tput_accepts", acc, 100);
        chk("tput_outputs", nout, 100);
        chk("tput_first", first, 5);
        chk("tput_span", last - first, 99);

`ifdef INTERNAL_PRNG_EN
        drain();
        for (int k = 0; k < 3; k++) begin
            run_vec($sformatf("prng%0d", k), 32'h01020304, 32'h0, 32'h7C777BF2);
            sh[k] = out_share0;
        end
        chk("prng_share0_varies", sh[0] != sh[1] || sh[1] != sh[2], 1);
`else
        drain();
        in_valid = 1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            rnd_valid = (i % 2) == 1;
            in_share0 = $urandom;
            in_share1 = $urandom;
            rnd_data = {$urandom, $urandom};
            #1;
            if (rnd_ready) acc++;
            step();
        end
        chk("gate_accepts", acc, 10);
        sh[0] = 0;
`endif

        // Reset with 2 stored and 3 in flight: nothing may emerge afterwards.
        drain();
        out_ready = 0;
        rnd_valid = 1;
        in_valid = 1;
        repeat (2) step();
        in_valid = 0;
        repeat (6) step();
        in_valid = 1;
        repeat (3) step();
        in_valid = 0;
        chk("mid_credits", credits_used, 5);
        reset = 1;
        repeat (2) step();
        reset = 0;
        out_ready = 1;
        nout = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) nout++;
            step();
        end
        chk("mid_no_stale", nout, 0);
        chk("mid_credits_clear", credits_used, 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
